mux_tree_cfg_ctrl: RTL and testbench

MUX_TREE_CFG_CTRL -- requirements
Module: mux_tree_cfg_ctrl

---
 rtl/mux_tree_cfg_ctrl.sv | 123 ++++++++++++
 tb/tb_mux_tree_cfg_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_tree_cfg_ctrl.sv
// Configuration controller for a bank of 11-input routing muxes.
// Writes are encoded into a shadow register and only reach the active
// select bits (sram) when a commit runs. After the copy, the outputs are
// held stable for SETTLE_CYC cycles, and then done pulses for one cycle.
module mux_tree_cfg_ctrl #(
  parameter int NUM_MUX    = 8,
  parameter int AW         = 3,
  parameter int SETTLE_CYC = 3
) (
  input  logic                   prog_clk,
  input  logic                   pReset,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [AW-1:0]          cfg_addr,
  input  logic [3:0]             cfg_sel,
  input  logic                   commit,
  input  logic                   err_clr,
  output logic [NUM_MUX*4-1:0]   sram,
  output logic [NUM_MUX*4-1:0]   sram_inv,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err
);

  typedef enum logic [1:0] {IDLE, COMMIT, SETTLE} state_t;

  state_t                 state;
  logic [3:0]             cnt;
  logic [NUM_MUX*4-1:0]   shadow;
  logic [NUM_MUX*4-1:0]   active;
  logic                   write_hs;
  logic                   addr_ok;
  logic                   sel_ok;
  logic                   legal_wr;
  logic                   illegal_wr;

  // Select index to level bits {s3,s2,s1,s0}.
  // Indices 0..7 go through the level-4 leg (s3=1) with inverted low bits.
  // 8..10 are the direct legs. 11 parks the mux on the constant-1 leg.
  // Unused level-1 bits are driven to 0.
  function automatic logic [3:0] encode_sel(input logic [3:0] sel);
    logic [3:0] code;
    if (!sel[3]) begin
      code = {1'b1, ~sel[2:0]};
    end else begin
      case (sel)
        4'd8:    code = 4'b0110;
        4'd9:    code = 4'b0100;
        4'd10:   code = 4'b0010;
        default: code = 4'b0000;
      endcase
    end
    return code;
  endfunction

  assign cfg_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign sram       = active;
  assign sram_inv   = ~active;

  assign write_hs   = cfg_valid & cfg_ready;
  assign addr_ok    = ({{(32-AW){1'b0}}, cfg_addr} < 32'(NUM_MUX));
  assign sel_ok     = (cfg_sel < 4'd12);
  assign legal_wr   = write_hs & addr_ok & sel_ok;
  assign illegal_wr = write_hs & ~(addr_ok & sel_ok);

  // Shadow update. A legal write lands in the addressed 4-bit field.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      shadow <= '0;
    end else if (legal_wr) begin
      for (int k = 0; k < NUM_MUX; k++) begin
        if (cfg_addr == AW'(k)) begin
          shadow[4*k +: 4] <= encode_sel(cfg_sel);
        end
      end
    end
  end

  // Sticky error flag. A new illegal write wins over err_clr.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      cfg_err <= 1'b0;
    end else if (illegal_wr) begin
      cfg_err <= 1'b1;
    end else if (err_clr) begin
      cfg_err <= 1'b0;
    end
  end

  // Commit sequencer: copy shadow to active, hold for SETTLE_CYC cycles, pulse done.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      done   <= 1'b0;
      active <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (commit) state <= COMMIT;
        end
        COMMIT: begin
          active <= shadow;
          cnt    <= 4'(SETTLE_CYC - 1);
          state  <= SETTLE;
          done   <= (SETTLE_CYC == 1);
        end
        SETTLE: begin
          if (cnt == 4'd0) begin
            state <= IDLE;
          end else begin
            cnt  <= cnt - 4'd1;
            done <= (cnt == 4'd1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_tree_cfg_ctrl.sv
// Bench for mux_tree_cfg_ctrl. It uses a scoreboard of expected commit
// results, directed scenarios, and a randomized write/commit mix.
module tb_mux_tree_cfg_ctrl;

  localparam int NUM_MUX    = 8;
  localparam int AW         = 4;
  localparam int SETTLE_CYC = 3;

  logic                  prog_clk;
  logic                  pReset;
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [AW-1:0]         cfg_addr;
  logic [3:0]            cfg_sel;
  logic                  commit;
  logic                  err_clr;
  logic [NUM_MUX*4-1:0]  sram;
  logic [NUM_MUX*4-1:0]  sram_inv;
  logic                  busy;
  logic                  done;
  logic                  cfg_err;

  mux_tree_cfg_ctrl #(.NUM_MUX(NUM_MUX), .AW(AW), .SETTLE_CYC(SETTLE_CYC)) dut (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_addr (cfg_addr),
    .cfg_sel  (cfg_sel),
    .commit   (commit),
    .err_clr  (err_clr),
    .sram     (sram),
    .sram_inv (sram_inv),
    .busy     (busy),
    .done     (done),
    .cfg_err  (cfg_err)
  );

  typedef struct {
    logic [NUM_MUX*4-1:0] val;
    int                   cyc;
  } exp_t;

  exp_t exp_q[$];
  int   mshadow[NUM_MUX];
  int   mactive[NUM_MUX];
  bit   merr;
  int   cyc;
  int   checks;
  int   errors;

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  initial cyc = 0;
  always @(posedge prog_clk) cyc <= cyc + 1;

  // Reference encoding: 0..7 count down from 15; 8..11 step down by two from 6.
  function automatic logic [3:0] ref_enc(input int s);
    int v;
    if (s < 8) v = 15 - s;
    else       v = (11 - s) * 2;
    return 4'(v);
  endfunction

  function automatic logic [NUM_MUX*4-1:0] ref_bank(input int m[NUM_MUX]);
    logic [NUM_MUX*4-1:0] b;
    b = '0;
    for (int k = 0; k < NUM_MUX; k++) b[4*k +: 4] = ref_enc(m[k]);
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_MUX; k++) begin
      mshadow[k] = 11;
      mactive[k] = 11;
    end
    merr = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!cfg_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("idle_timeout", 32'(n), 32'd0);
  endtask

  // One driven cycle. The model is updated with the effect of the next edge.
  task automatic drive(input bit vld, input int a, input int s, input bit clr,
                       input bit cmt, input bit expect_done);
    wait_idle();
    cfg_valid = vld;
    cfg_addr  = AW'(a);
    cfg_sel   = 4'(s);
    err_clr   = clr;
    commit    = cmt;
    if (vld) begin
      if (a < NUM_MUX && s < 12) mshadow[a] = s;
      else                       merr = 1'b1;
    end
    if (clr && !(vld && !(a < NUM_MUX && s < 12))) merr = 1'b0;
    if (cmt) begin
      mactive = mshadow;
      if (expect_done) exp_q.push_back('{ref_bank(mshadow), cyc + 1 + SETTLE_CYC});
    end
    step();
    cfg_valid = 1'b0;
    err_clr   = 1'b0;
    commit    = 1'b0;
    chk("cfg_err", 32'(cfg_err), 32'(merr));
  endtask

  // Monitor: every done pulse must match the oldest outstanding commit.
  always @(negedge prog_clk) begin
    if (!pReset) begin
      chk("sram_inv", 32'(sram_inv), 32'(~sram));
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("spurious_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("commit_sram", 32'(sram), 32'(e.val));
          chk("done_latency", 32'(cyc), 32'(e.cyc));
          chk("busy_at_done", 32'(busy), 32'd1);
        end
      end
    end
  end

  initial begin
    checks = 0; errors = 0;
    cfg_valid = 1'b0; cfg_addr = '0; cfg_sel = '0; commit = 1'b0; err_clr = 1'b0;
    pReset = 1'b1;
    model_reset();
    repeat (3) step();
    pReset = 1'b0;
    step();

    // Reset state
    chk("rst_sram", 32'(sram), 32'd0);
    chk("rst_sram_inv", 32'(sram_inv), 32'hFFFF_FFFF);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);

    // Shadow isolation: a written field stays invisible until commit
    drive(1, 2, 5, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      chk("iso_hold", 32'(sram[11:8]), 32'(ref_enc(mactive[2])));
      step();
    end
    drive(0, 0, 0, 0, 1, 1);
    chk("iso_before_copy", 32'(sram[11:8]), 32'h0);
    step();
    chk("iso_after_copy", 32'(sram[11:8]), 32'b1010);

    // Encoding sweep on mux 0, each followed by a commit, then a commit while busy
    for (int s = 0; s < 12; s++) begin
      drive(1, 0, s, 0, 0, 1);
      drive(0, 0, 0, 0, 1, 1);
      commit = 1'b1;
      step();
      commit = 1'b0;
      wait_idle();
      chk("sweep_sram0", 32'(sram[3:0]), 32'(ref_enc(s)));
    end

    // Same-cycle write and commit
    drive(1, 7, 9, 0, 1, 1);
    for (int i = 0; i < 1 + SETTLE_CYC; i++) begin
      chk("wc_ready_low", 32'(cfg_ready), 32'd0);
      step();
    end
    chk("wc_ready_back", 32'(cfg_ready), 32'd1);
    chk("wc_sram7", 32'(sram[31:28]), 32'b0100);

    // Illegal writes, err_clr priority, and shadow left unchanged
    drive(1, 1, 12, 0, 0, 1);
    drive(1, 8, 3, 0, 0, 1);
    drive(1, 9, 0, 1, 0, 1);
    drive(0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 1, 1);
    wait_idle();

    // Reset in the second SETTLE cycle aborts the commit
    drive(1, 3, 4, 0, 1, 0);
    step();
    step();
    pReset = 1'b1;
    #1;
    model_reset();
    chk("abort_sram", 32'(sram), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    step();
    pReset = 1'b0;
    step();
    chk("abort_ready", 32'(cfg_ready), 32'd1);
    chk("abort_err", 32'(cfg_err), 32'd0);

    // Randomized writes, clears and commits
    for (int i = 0; i < 60; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 9), $urandom_range(0, 13),
            $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0, 1);
    end
    drive(0, 0, 0, 0, 1, 1);

    // Drain outstanding commits with a bounded wait
    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
        step();
        n++;
      end
      chk("drain_pending", 32'(exp_q.size()), 32'd0);
    end
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
